// File: rtl/seq_det_ctrl.sv
// Streaming serial pattern detector: accepts parallel words over valid/ready, shifts them
// MSB-first through a programmable pattern window, counts matches and raises a sticky IRQ.
module seq_det_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              CFG_WE,
  input  logic [PAT_W-1:0]  CFG_PATTERN,
  input  logic [CNT_W-1:0]  CFG_THRESH,
  input  logic              CFG_OVERLAP,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              IN_READY,
  output logic              BUSY,
  output logic              MATCH,
  output logic [CNT_W-1:0]  MATCH_COUNT,
  output logic              IRQ,
  input  logic              IRQ_CLR
);

  localparam int BC_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [PAT_W-1:0] PAT_RST  = PAT_W'(4'b0111);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   shreg;
  logic [BC_W-1:0]     bitcnt;
  logic [PAT_W-1:0]    window, win_next;
  logic [FILL_W-1:0]   fill, fill_base, fill_next;
  logic [PAT_W-1:0]    pattern;
  logic [CNT_W-1:0]    thresh;
  logic                overlap;
  logic                match_q, match_next;
  logic [CNT_W-1:0]    count;
  logic                irq_q;

  logic accept, load, shifting, last_bit, cfg_take, count_inc, irq_set;

  assign shifting = (state == SHIFT);
  assign last_bit = (bitcnt == '0);
  assign IN_READY = ENABLE && ((state == IDLE) || (shifting && last_bit));
  assign accept   = IN_VALID && IN_READY;
  // Configuration only lands between words; a simultaneous accept takes priority.
  assign cfg_take = CFG_WE && (state == IDLE) && !accept;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          load       = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (accept) load = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // In non-overlap mode a flagged match empties the window before the new bit counts.
  always_comb begin
    win_next   = {window[PAT_W-2:0], shreg[DATA_W-1]};
    fill_base  = (!overlap && match_q) ? '0 : fill;
    fill_next  = (fill_base == FILL_FULL) ? fill_base : fill_base + 1'b1;
    match_next = shifting && (fill_next == FILL_FULL) && (win_next == pattern);
    count_inc  = match_next && (count != CNT_MAX);
    irq_set    = count_inc && (thresh != '0) && ((count + 1'b1) == thresh);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      window  <= '0;
      fill    <= '0;
      pattern <= PAT_RST;
      thresh  <= '0;
      overlap <= 1'b1;
      match_q <= 1'b0;
      count   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state   <= state_next;
      match_q <= match_next;

      if (load) begin
        shreg  <= IN_DATA;
        bitcnt <= BC_W'(DATA_W - 1);
      end else if (shifting) begin
        shreg <= {shreg[DATA_W-2:0], 1'b0};
        if (!last_bit) bitcnt <= bitcnt - 1'b1;
      end

      if (cfg_take) begin
        pattern <= CFG_PATTERN;
        thresh  <= CFG_THRESH;
        overlap <= CFG_OVERLAP;
        window  <= '0;
        fill    <= '0;
        count   <= '0;
        irq_q   <= 1'b0;
      end else begin
        if (shifting) begin
          window <= win_next;
          fill   <= fill_next;
        end
        if (count_inc) count <= count + 1'b1;
        // Set beats clear when both land on the same edge.
        if (irq_set)      irq_q <= 1'b1;
        else if (IRQ_CLR) irq_q <= 1'b0;
      end
    end
  end

  assign BUSY        = shifting;
  assign MATCH       = match_q;
  assign MATCH_COUNT = count;
  assign IRQ         = irq_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl (DATA_W=8, PAT_W=4, CNT_W=8).
module tb_seq_det_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ENABLE;
  logic       CFG_WE;
  logic [3:0] CFG_PATTERN;
  logic [7:0] CFG_THRESH;
  logic       CFG_OVERLAP;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_READY;
  logic       BUSY;
  logic       MATCH;
  logic [7:0] MATCH_COUNT;
  logic       IRQ;
  logic       IRQ_CLR;

  int n_checks = 0;
  int n_pass   = 0;

  seq_det_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CFG_WE(CFG_WE),
    .CFG_PATTERN(CFG_PATTERN), .CFG_THRESH(CFG_THRESH), .CFG_OVERLAP(CFG_OVERLAP),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY), .BUSY(BUSY),
    .MATCH(MATCH), .MATCH_COUNT(MATCH_COUNT), .IRQ(IRQ), .IRQ_CLR(IRQ_CLR)
  );

  always #5 CLK = ~CLK;

  // Outputs are observed 1 time unit after the rising edge; inputs change there too.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input logic [3:0] pat, input logic [7:0] thr, input logic ov);
    IN_VALID    = 1'b0;
    CFG_WE      = 1'b1;
    CFG_PATTERN = pat;
    CFG_THRESH  = thr;
    CFG_OVERLAP = ov;
    tick;
    CFG_WE      = 1'b0;
  endtask

  // Accept one word at edge t, then record MATCH/BUSY after edges t+1..t+n.
  task automatic send(input logic [7:0] d, input int n,
                      output logic [31:0] mv, output logic [31:0] bv);
    mv = '0;
    bv = '0;
    IN_VALID = 1'b1;
    IN_DATA  = d;
    tick;
    IN_VALID = 1'b0;
    bv[0] = BUSY;
    for (int i = 1; i <= n; i++) begin
      tick;
      mv[i] = MATCH;
      bv[i] = BUSY;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick;
    tick;
    RESET = 1'b0;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
    n_checks++; if (MATCH !== 1'b0) $display("FAIL reset_match: got %b want 0", MATCH); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd0) $display("FAIL reset_count: got %0d want 0", MATCH_COUNT); else n_pass++;
    n_checks++; if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b want 0", IRQ); else n_pass++;
    n_checks++; if (IN_READY !== 1'b1) $display("FAIL reset_ready: got %b want 1", IN_READY); else n_pass++;
  endtask

  task automatic test_default_pattern;
    logic [31:0] mv, bv;
    send(8'b0111_0111, 9, mv, bv);
    n_checks++; if (mv !== 32'h0000_0110) $display("FAIL default_match: got %h want %h", mv, 32'h110); else n_pass++;
    n_checks++; if (bv !== 32'h0000_00FF) $display("FAIL default_busy: got %h want %h", bv, 32'hFF); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd2) $display("FAIL default_count: got %0d want 2", MATCH_COUNT); else n_pass++;
    n_checks++; if (IRQ !== 1'b0) $display("FAIL default_irq: got %b want 0", IRQ); else n_pass++;
  endtask

  task automatic test_overlap;
    logic [31:0] mv, bv;
    cfg(4'b1111, 8'd0, 1'b1);
    send(8'hFF, 9, mv, bv);
    n_checks++; if (mv !== 32'h0000_01F0) $display("FAIL ovl_match: got %h want %h", mv, 32'h1F0); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd5) $display("FAIL ovl_count: got %0d want 5", MATCH_COUNT); else n_pass++;
    cfg(4'b1111, 8'd0, 1'b0);
    n_checks++; if (MATCH_COUNT !== 8'd0) $display("FAIL cfg_clr_count: got %0d want 0", MATCH_COUNT); else n_pass++;
    send(8'hFF, 9, mv, bv);
    n_checks++; if (mv !== 32'h0000_0110) $display("FAIL novl_match: got %h want %h", mv, 32'h110); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd2) $display("FAIL novl_count: got %0d want 2", MATCH_COUNT); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] mv, bv;
    logic        rdy7;
    cfg(4'b0111, 8'd0, 1'b1);
    mv = '0;
    bv = '0;
    rdy7 = 1'b0;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h01;
    tick;
    IN_DATA  = 8'hC0;
    for (int i = 1; i <= 17; i++) begin
      tick;
      if (i == 7) rdy7 = IN_READY;
      if (i == 8) IN_VALID = 1'b0;
      mv[i] = MATCH;
      bv[i] = BUSY;
    end
    n_checks++; if (rdy7 !== 1'b1) $display("FAIL b2b_ready: got %b want 1", rdy7); else n_pass++;
    n_checks++; if (bv !== 32'h0000_FFFE) $display("FAIL b2b_busy: got %h want %h", bv, 32'hFFFE); else n_pass++;
    n_checks++; if (mv !== 32'h0000_0400) $display("FAIL b2b_match: got %h want %h", mv, 32'h400); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd1) $display("FAIL b2b_count: got %0d want 1", MATCH_COUNT); else n_pass++;
  endtask

  task automatic test_threshold_irq;
    logic [31:0] iv;
    cfg(4'b1111, 8'd3, 1'b1);
    iv = '0;
    IN_VALID = 1'b1;
    IN_DATA  = 8'hFF;
    tick;
    IN_VALID = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick;
      iv[i] = IRQ;
    end
    n_checks++; if (iv !== 32'h0000_03C0) $display("FAIL irq_rise: got %h want %h", iv, 32'h3C0); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd5) $display("FAIL irq_count: got %0d want 5", MATCH_COUNT); else n_pass++;
    IRQ_CLR = 1'b1;
    tick;
    IRQ_CLR = 1'b0;
    n_checks++; if (IRQ !== 1'b0) $display("FAIL irq_clr: got %b want 0", IRQ); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd5) $display("FAIL irq_clr_count: got %0d want 5", MATCH_COUNT); else n_pass++;

    // Clear asserted on the very edge the threshold is hit: set must win.
    cfg(4'b1111, 8'd3, 1'b1);
    iv = '0;
    IN_VALID = 1'b1;
    IN_DATA  = 8'hFF;
    tick;
    IN_VALID = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      IRQ_CLR = (i == 6);
      tick;
      iv[i] = IRQ;
    end
    IRQ_CLR = 1'b0;
    n_checks++; if (iv !== 32'h0000_03C0) $display("FAIL irq_set_wins: got %h want %h", iv, 32'h3C0); else n_pass++;
  endtask

  task automatic test_cfg_busy_and_reset;
    logic [31:0] mv;
    logic        any_match;
    cfg(4'b0111, 8'd0, 1'b1);
    mv = '0;
    IN_VALID = 1'b1;
    IN_DATA  = 8'b0111_0111;
    tick;
    IN_VALID = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      CFG_WE = (i == 3);
      if (i == 3) begin
        CFG_PATTERN = 4'b0000;
        CFG_THRESH  = 8'd1;
        CFG_OVERLAP = 1'b0;
      end
      tick;
      mv[i] = MATCH;
    end
    CFG_WE = 1'b0;
    n_checks++; if (mv !== 32'h0000_0110) $display("FAIL cfgbusy_match: got %h want %h", mv, 32'h110); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd2) $display("FAIL cfgbusy_count: got %0d want 2", MATCH_COUNT); else n_pass++;
    n_checks++; if (IRQ !== 1'b0) $display("FAIL cfgbusy_irq: got %b want 0", IRQ); else n_pass++;

    // Abort a word mid-flight after its first match has been counted.
    cfg(4'b0111, 8'd0, 1'b1);
    IN_VALID = 1'b1;
    IN_DATA  = 8'b0111_0111;
    tick;
    IN_VALID = 1'b0;
    for (int i = 1; i <= 4; i++) tick;
    n_checks++; if (MATCH_COUNT !== 8'd1) $display("FAIL prerst_count: got %0d want 1", MATCH_COUNT); else n_pass++;
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL midrst_busy: got %b want 0", BUSY); else n_pass++;
    n_checks++; if (MATCH_COUNT !== 8'd0) $display("FAIL midrst_count: got %0d want 0", MATCH_COUNT); else n_pass++;
    n_checks++; if (IN_READY !== 1'b1) $display("FAIL midrst_ready: got %b want 1", IN_READY); else n_pass++;
    any_match = MATCH;
    for (int i = 0; i < 6; i++) begin
      tick;
      any_match = any_match | MATCH;
    end
    n_checks++; if (any_match !== 1'b0) $display("FAIL midrst_nomatch: got %b want 0", any_match); else n_pass++;
  endtask

  task automatic test_enable_drop;
    logic [31:0] bv, rv;
    bv = '0;
    rv = '0;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h55;
    tick;
    for (int i = 1; i <= 11; i++) begin
      if (i == 3) ENABLE = 1'b0;
      tick;
      bv[i] = BUSY;
      rv[i] = IN_READY;
    end
    n_checks++; if (bv !== 32'h0000_00FE) $display("FAIL endrop_busy: got %h want %h", bv, 32'hFE); else n_pass++;
    n_checks++; if (rv !== 32'h0000_0000) $display("FAIL endrop_ready: got %h want 0", rv); else n_pass++;
    ENABLE = 1'b1;
    #1;
    n_checks++; if (IN_READY !== 1'b1) $display("FAIL enret_ready: got %b want 1", IN_READY); else n_pass++;
    tick;
    IN_VALID = 1'b0;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL enret_busy: got %b want 1", BUSY); else n_pass++;
    for (int i = 0; i < 9; i++) tick;
  endtask

  initial begin
    RESET       = 1'b1;
    ENABLE      = 1'b1;
    CFG_WE      = 1'b0;
    CFG_PATTERN = 4'b0000;
    CFG_THRESH  = 8'd0;
    CFG_OVERLAP = 1'b1;
    IN_VALID    = 1'b0;
    IN_DATA     = 8'h00;
    IRQ_CLR     = 1'b0;
    #2;
    test_reset;
    test_default_pattern;
    test_overlap;
    test_back_to_back;
    test_threshold_irq;
    test_cfg_busy_and_reset;
    test_enable_drop;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
